// File: rtl/apb2wb_pkg.sv
// Shared types and widths for the APB4 to pipelined Wishbone B4 bridge.
package apb2wb_pkg;

   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_e;

   // Error and retry both surface as an APB slave error.
   function automatic logic rsp_is_fail(input logic err, input logic rty);
      return err | rty;
   endfunction

endpackage

// File: rtl/apb2wb_if.sv
// Bus bundle for the bridge: APB4 requester side, Wishbone slave side and FSM state.
interface apb2wb_if #(
   parameter int ADDR_W = 32
);
   import apb2wb_pkg::*;

   // APB: a transfer is offered while psel_i&penable_i and completes on the
   // single cycle pready_o=1; Wishbone: stb is accepted on a cycle with
   // wb_stall_i=0 and the transaction ends on the first ack/err/rty after that.
   logic                psel_i;
   logic                penable_i;
   logic                pwrite_i;
   logic [ADDR_W-1:0]   paddr_i;
   logic [DATA_W-1:0]   pwdata_i;
   logic [SEL_W-1:0]    pstrb_i;
   logic                pready_o;
   logic [DATA_W-1:0]   prdata_o;
   logic                pslverr_o;

   logic                wb_cyc_o;
   logic                wb_stb_o;
   logic                wb_we_o;
   logic [ADDR_W-1:0]   wb_adr_o;
   logic [SEL_W-1:0]    wb_sel_o;
   logic [DATA_W-1:0]   wb_dat_o;
   logic                wb_ack_i;
   logic                wb_err_i;
   logic                wb_rty_i;
   logic                wb_stall_i;
   logic [DATA_W-1:0]   wb_dat_i;

   state_e              dbg_state;

   // The bridge view: APB completer and Wishbone initiator.
   modport master (
      input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
      output pready_o, prdata_o, pslverr_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i,
      output dbg_state
   );

   // The environment view: APB requester and Wishbone target.
   modport slave (
      output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
      input  pready_o, prdata_o, pslverr_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i,
      input  dbg_state
   );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Counts bus cycles spent waiting on Wishbone; flags the last allowed cycle.
module wb_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;

   // expired is high during the TIMEOUT-th counted cycle so the FSM leaves on that edge.
   assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clr) begin
         cnt_q <= '0;
      end else if (en && !expired) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/apb2wb_bridge.sv
// APB4 completer that issues one pipelined Wishbone B4 transaction per APB transfer.
module apb2wb_bridge
   import apb2wb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   apb2wb_if.master  bus
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   adr_q;
   logic [DATA_W-1:0]   wdat_q;
   logic [DATA_W-1:0]   rdat_q;
   logic [SEL_W-1:0]    sel_q;
   logic                we_q;
   logic                err_q;

   logic                accept;
   logic                rsp_any;
   logic                tmo_clr;
   logic                tmo_en;
   logic                tmo_expired;
   logic                done_entry;
   logic                done_err;
   logic [DATA_W-1:0]   done_rdat;

   assign accept  = bus.psel_i & bus.penable_i;
   assign rsp_any = bus.wb_ack_i | bus.wb_err_i | bus.wb_rty_i;

   // Read data is only captured on a clean ack; err/rty/timeout force zero.
   assign done_rdat = (!done_err && !we_q) ? bus.wb_dat_i : '0;

   wb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d    = state_q;
      tmo_clr    = 1'b0;
      tmo_en     = 1'b0;
      done_entry = 1'b0;
      done_err   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = REQ;
               tmo_clr = 1'b1;
            end
         end
         REQ: begin
            tmo_en = 1'b1;
            // A response only counts once the strobe has been accepted.
            if (!bus.wb_stall_i && rsp_any) begin
               state_d    = DONE;
               done_entry = 1'b1;
               done_err   = rsp_is_fail(bus.wb_err_i, bus.wb_rty_i);
            end else if (tmo_expired) begin
               state_d    = DONE;
               done_entry = 1'b1;
               done_err   = 1'b1;
            end else if (!bus.wb_stall_i) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            tmo_en = 1'b1;
            if (rsp_any) begin
               state_d    = DONE;
               done_entry = 1'b1;
               done_err   = rsp_is_fail(bus.wb_err_i, bus.wb_rty_i);
            end else if (tmo_expired) begin
               state_d    = DONE;
               done_entry = 1'b1;
               done_err   = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         adr_q   <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && accept) begin
            adr_q  <= bus.paddr_i;
            wdat_q <= bus.pwdata_i;
            we_q   <= bus.pwrite_i;
            sel_q  <= bus.pwrite_i ? bus.pstrb_i : '1;
         end
         if (done_entry) begin
            err_q  <= done_err;
            rdat_q <= done_rdat;
         end
      end
   end

   assign bus.wb_cyc_o  = (state_q == REQ) || (state_q == WAIT);
   assign bus.wb_stb_o  = (state_q == REQ);
   assign bus.wb_we_o   = we_q;
   assign bus.wb_adr_o  = adr_q;
   assign bus.wb_sel_o  = sel_q;
   assign bus.wb_dat_o  = wdat_q;
   assign bus.pready_o  = (state_q == DONE);
   assign bus.pslverr_o = (state_q == DONE) && err_q;
   assign bus.prdata_o  = rdat_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_apb2wb_bridge.sv
// Randomized APB transfers against a scripted Wishbone target, checked by a transaction-level model.
module tb_apb2wb_bridge;
   import apb2wb_pkg::*;

   localparam int ADDR_W = 32;
   localparam int TO     = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   apb2wb_if #(.ADDR_W(ADDR_W)) bus ();

   apb2wb_bridge #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TO)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   // clock/reset block
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [32:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Transaction-level model: s stall cycles, response d cycles after the strobe is taken.
   // rsp = {err, rty, ack}; returns cycles spent with cyc high and {pslverr, prdata}.
   function automatic void model_txn(input logic we, input int s, input int d, input logic [2:0] rsp,
                                     input logic [31:0] sdat, output int n, output logic [32:0] res);
      if (rsp != 3'b000 && (s + d) < TO) begin
         n = s + d + 1;
         if (rsp[2] || rsp[1]) res = {1'b1, 32'h0};
         else                  res = {1'b0, we ? 32'h0 : sdat};
      end else begin
         n   = TO;
         res = {1'b1, 32'h0};
      end
   endfunction

   task automatic idle_bus();
      bus.psel_i     = 1'b0;
      bus.penable_i  = 1'b0;
      bus.pwrite_i   = 1'b0;
      bus.paddr_i    = '0;
      bus.pwdata_i   = '0;
      bus.pstrb_i    = '0;
      bus.wb_ack_i   = 1'b0;
      bus.wb_err_i   = 1'b0;
      bus.wb_rty_i   = 1'b0;
      bus.wb_stall_i = 1'b0;
      bus.wb_dat_i   = '0;
   endtask

   task automatic apb_setup(input logic we, input logic [ADDR_W-1:0] adr, input logic [31:0] wdat,
                            input logic [3:0] strb);
      @(posedge clk); #1;
      bus.psel_i    = 1'b1;
      bus.penable_i = 1'b0;
      bus.pwrite_i  = we;
      bus.paddr_i   = adr;
      bus.pwdata_i  = wdat;
      bus.pstrb_i   = strb;
      @(posedge clk); #1;
      bus.penable_i = 1'b1;
      @(posedge clk); #1;
   endtask

   // driver: one full APB transfer with a scripted Wishbone target
   task automatic run_txn(input logic we, input logic [ADDR_W-1:0] adr, input logic [31:0] wdat,
                          input logic [3:0] strb, input int s, input int d, input logic [2:0] rsp,
                          input logic [31:0] sdat, input logic drop_psel, input logic stray);
      int          n;
      logic [32:0] res;
      logic [32:0] exp;
      logic        hit;
      model_txn(we, s, d, rsp, sdat, n, res);
      exp_q.push_back(res);
      bus.wb_dat_i = sdat;
      apb_setup(we, adr, wdat, strb);
      for (int k = 0; k < n; k++) begin
         hit = (rsp != 3'b000) && (k == s + d);
         bus.wb_stall_i = (k < s);
         bus.wb_ack_i   = hit & rsp[0];
         bus.wb_rty_i   = hit & rsp[1];
         bus.wb_err_i   = hit & rsp[2];
         if (drop_psel && k > 0) begin
            bus.psel_i    = 1'b0;
            bus.penable_i = 1'b0;
         end
         @(negedge clk);
         check("cyc_busy", bus.wb_cyc_o, 1'b1);
         check("stb", bus.wb_stb_o, (k <= s));
         check("pready_busy", bus.pready_o, 1'b0);
         check("state_busy", bus.dbg_state, (k <= s) ? REQ : WAIT);
         if (k <= s) begin
            check("adr", bus.wb_adr_o, adr);
            check("we", bus.wb_we_o, we);
            check("sel", bus.wb_sel_o, we ? strb : 4'hF);
            if (we) check("wdat", bus.wb_dat_o, wdat);
         end
         @(posedge clk); #1;
      end
      bus.wb_stall_i = 1'b0;
      bus.wb_err_i   = 1'b0;
      bus.wb_rty_i   = 1'b0;
      bus.wb_ack_i   = stray;
      @(negedge clk);
      exp = exp_q.pop_front();
      check("pready_done", bus.pready_o, 1'b1);
      check("cyc_done", bus.wb_cyc_o, 1'b0);
      check("stb_done", bus.wb_stb_o, 1'b0);
      check("pslverr", bus.pslverr_o, exp[32]);
      check("prdata", bus.prdata_o, exp[31:0]);
      @(posedge clk); #1;
      bus.psel_i    = 1'b0;
      bus.penable_i = 1'b0;
      bus.wb_ack_i  = 1'b0;
      @(negedge clk);
      check("pready_after", bus.pready_o, 1'b0);
      check("cyc_after", bus.wb_cyc_o, 1'b0);
      check("pslverr_after", bus.pslverr_o, 1'b0);
   endtask

   task automatic reset_in_wait();
      bus.wb_dat_i = 32'hCAFE_F00D;
      apb_setup(1'b0, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      check("rst_req_stb", bus.wb_stb_o, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_wait_cyc", bus.wb_cyc_o, 1'b1);
      check("rst_wait_stb", bus.wb_stb_o, 1'b0);
      rst_n         = 1'b0;
      bus.psel_i    = 1'b0;
      bus.penable_i = 1'b0;
      @(posedge clk); #1;
      rst_n        = 1'b1;
      bus.wb_ack_i = 1'b1;
      @(negedge clk);
      check("rst_cyc", bus.wb_cyc_o, 1'b0);
      check("rst_pready", bus.pready_o, 1'b0);
      check("rst_state", bus.dbg_state, IDLE);
      @(posedge clk); #1;
      bus.wb_ack_i = 1'b0;
      @(negedge clk);
      check("late_ack_pready", bus.pready_o, 1'b0);
      check("late_ack_cyc", bus.wb_cyc_o, 1'b0);
   endtask

   initial begin
      logic [2:0] rsp;
      int         r;
      idle_bus();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cyc0", bus.wb_cyc_o, 1'b0);
      check("rst_stb0", bus.wb_stb_o, 1'b0);
      check("rst_we0", bus.wb_we_o, 1'b0);
      check("rst_adr0", bus.wb_adr_o, '0);
      check("rst_sel0", bus.wb_sel_o, '0);
      check("rst_dat0", bus.wb_dat_o, '0);
      check("rst_pready0", bus.pready_o, 1'b0);
      check("rst_prdata0", bus.prdata_o, '0);
      check("rst_pslverr0", bus.pslverr_o, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // directed cases
      run_txn(1'b1, 32'h4, 32'h0000_0123, 4'hF, 0, 1, 3'b001, 32'h0, 1'b0, 1'b0);
      run_txn(1'b0, 32'h0, 32'h0, 4'h0, 3, 1, 3'b001, 32'hDEAD_BEEF, 1'b0, 1'b0);
      run_txn(1'b1, 32'h8, 32'h5555_AAAA, 4'b0101, 0, 1, 3'b100, 32'h0, 1'b0, 1'b0);
      run_txn(1'b0, 32'hC, 32'h0, 4'h0, 0, 0, 3'b000, 32'h1234_5678, 1'b0, 1'b0);
      run_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, 3'b101, 32'h7777_7777, 1'b0, 1'b0);
      run_txn(1'b0, 32'h24, 32'h0, 4'h0, 1, 2, 3'b010, 32'h8888_8888, 1'b0, 1'b1);
      run_txn(1'b0, 32'h28, 32'h0, 4'h0, 0, 7, 3'b001, 32'h0BAD_0BAD, 1'b1, 1'b0);
      reset_in_wait();
      run_txn(1'b0, 32'h30, 32'h0, 4'h0, 0, 1, 3'b001, 32'h600D_D00D, 1'b0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)     rsp = 3'b000;
         else if (r < 6) rsp = 3'b001;
         else            rsp = 3'($urandom_range(1, 7));
         run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                 4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 6), rsp,
                 $urandom, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end

      check("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
